// File: rtl/arbiter_router_router.sv
// Steers {addr, data} messages into per-output FIFOs and strips the addr.
// Define ROUTER_BYPASS_EN to let a message skip an empty FIFO into a ready output.
module arbiter_router_router #(
   parameter int nbits    = 32,
   parameter int noutputs = 3,
   parameter int depth    = 2
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              istream_val,
   output logic                              istream_rdy,
   input  logic [$clog2(noutputs)+nbits-1:0] istream_msg,
   output logic [0:noutputs-1]               ostream_val,
   input  logic [0:noutputs-1]               ostream_rdy,
   output logic [noutputs*nbits-1:0]         ostream_msg
);

   localparam int addr_nbits = $clog2(noutputs);
   localparam int PW = (depth > 1) ? $clog2(depth) : 1;
   localparam int CW = $clog2(depth + 1);

   logic [addr_nbits-1:0] addr;
   logic [nbits-1:0]      data;

   logic [nbits-1:0] mem_q  [noutputs][depth];
   logic [PW-1:0]    head_q [noutputs];
   logic [PW-1:0]    head_d [noutputs];
   logic [PW-1:0]    tail_q [noutputs];
   logic [PW-1:0]    tail_d [noutputs];
   logic [CW-1:0]    cnt_q  [noutputs];
   logic [CW-1:0]    cnt_d  [noutputs];

   logic [noutputs-1:0] hit, full, empty, byp, enq, deq;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(depth - 1)) ? '0 : p + 1'b1;
   endfunction

   assign addr = istream_msg[addr_nbits+nbits-1:nbits];
   assign data = istream_msg[nbits-1:0];

   always_comb begin
      hit   = '0;
      full  = '0;
      empty = '0;
      byp   = '0;
      for (int i = 0; i < noutputs; i++) begin
         hit[i]   = (addr == addr_nbits'(i));
         full[i]  = (cnt_q[i] == CW'(depth));
         empty[i] = (cnt_q[i] == '0);
`ifdef ROUTER_BYPASS_EN
         byp[i]   = ~reset & istream_val & hit[i] & empty[i] & ostream_rdy[i];
`endif
      end
   end

   // Out-of-range addrs never hit, so they are always accepted and dropped.
   always_comb begin
      istream_rdy = ~reset;
      for (int i = 0; i < noutputs; i++)
         if (hit[i] && full[i]) istream_rdy = 1'b0;
   end

   always_comb begin
      enq         = '0;
      deq         = '0;
      ostream_val = '0;
      ostream_msg = '0;
      for (int i = 0; i < noutputs; i++) begin
         enq[i] = istream_val & istream_rdy & hit[i] & ~byp[i];
         deq[i] = ~reset & ~empty[i] & ostream_rdy[i];
         ostream_val[i] = ~reset & (~empty[i] | byp[i]);
         ostream_msg[(noutputs-1-i)*nbits +: nbits] =
            byp[i] ? data : mem_q[i][head_q[i]];
      end
   end

   always_comb begin
      for (int i = 0; i < noutputs; i++) begin
         head_d[i] = deq[i] ? inc(head_q[i]) : head_q[i];
         tail_d[i] = enq[i] ? inc(tail_q[i]) : tail_q[i];
         cnt_d[i]  = cnt_q[i] + CW'(enq[i]) - CW'(deq[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < noutputs; i++) begin
            head_q[i] <= '0;
            tail_q[i] <= '0;
            cnt_q[i]  <= '0;
            for (int j = 0; j < depth; j++)
               mem_q[i][j] <= '0;
         end
      end else begin
         for (int i = 0; i < noutputs; i++) begin
            head_q[i] <= head_d[i];
            tail_q[i] <= tail_d[i];
            cnt_q[i]  <= cnt_d[i];
            if (enq[i]) mem_q[i][tail_q[i]] <= data;
         end
      end
   end

endmodule

// File: tb/tb_arbiter_router_router.sv
// Directed bench for arbiter_router_router (nbits=32, noutputs=3, depth=2).
module tb_arbiter_router_router;

   logic        clk = 1'b0;
   logic        reset;
   logic        istream_val;
   logic        istream_rdy;
   logic [33:0] istream_msg;
   logic [0:2]  ostream_val;
   logic [0:2]  ostream_rdy;
   logic [95:0] ostream_msg;

   int checks = 0;
   int errors = 0;

   arbiter_router_router #(
      .nbits(32), .noutputs(3), .depth(2)
   ) dut (
      .clk(clk),
      .reset(reset),
      .istream_val(istream_val),
      .istream_rdy(istream_rdy),
      .istream_msg(istream_msg),
      .ostream_val(ostream_val),
      .ostream_rdy(ostream_rdy),
      .ostream_msg(ostream_msg)
   );

   always #5 clk = ~clk;

   logic [31:0] s0, s1, s2;
   assign s0 = ostream_msg[64 +: 32];
   assign s1 = ostream_msg[32 +: 32];
   assign s2 = ostream_msg[0  +: 32];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] a, input logic [31:0] d);
      istream_val = 1'b1;
      istream_msg = {a, d};
      #1;
   endtask

   function automatic logic [2:0] onehot(input int a);
      return 3'b100 >> a;
   endfunction

   initial begin
      reset       = 1'b1;
      istream_val = 1'b0;
      istream_msg = '0;
      ostream_rdy = 3'b000;

      // 1: reset
      step();
      chk("rst_rdy", 32'(istream_rdy), 32'd0);
      chk("rst_val", 32'(ostream_val), 32'd0);
      step();
      reset = 1'b0;
      #1;
      chk("post_rdy", 32'(istream_rdy), 32'd1);
      chk("post_val", 32'(ostream_val), 32'd0);
      chk("post_msg0", s0, 32'd0);
      chk("post_msg1", s1, 32'd0);
      chk("post_msg2", s2, 32'd0);

      // 2: single word to output 1
      ostream_rdy = 3'b111;
      send(2'd1, 32'hDEADBEEF);
      chk("t2_rdy", 32'(istream_rdy), 32'd1);
      step();
      istream_val = 1'b0;
      #1;
      chk("t2_val", 32'(ostream_val), 32'(3'b010));
      chk("t2_msg", s1, 32'hDEADBEEF);
      step();
      chk("t2_idle", 32'(ostream_val), 32'd0);

      // 3: fill output 0, back-pressure, then drain in order
      ostream_rdy = 3'b011;
      send(2'd0, 32'h11);
      chk("t3_rdyA", 32'(istream_rdy), 32'd1);
      step();
      send(2'd0, 32'h22);
      chk("t3_rdyB", 32'(istream_rdy), 32'd1);
      step();
      send(2'd0, 32'h33);
      chk("t3_fullC", 32'(istream_rdy), 32'd0);
      chk("t3_val0", 32'(ostream_val), 32'(3'b100));
      chk("t3_headA", s0, 32'h11);
      step();
      chk("t3_stall", 32'(istream_rdy), 32'd0);
      ostream_rdy = 3'b111;
      #1;
      chk("t3_fulldeq", 32'(istream_rdy), 32'd0);
      step();
      chk("t3_headB", s0, 32'h22);
      chk("t3_rdyC", 32'(istream_rdy), 32'd1);
      step();
      istream_val = 1'b0;
      #1;
      chk("t3_valC", 32'(ostream_val), 32'(3'b100));
      chk("t3_headC", s0, 32'h33);
      step();
      chk("t3_empty", 32'(ostream_val), 32'd0);

      // 4: out-of-range addr is consumed and dropped
      send(2'd3, 32'hCAFEF00D);
      chk("t4_rdy", 32'(istream_rdy), 32'd1);
      step();
      istream_val = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("t4_val", 32'(ostream_val), 32'd0);
         step();
      end

      // 5a: 10 back-to-back words to output 2
      for (int k = 0; k < 10; k++) begin
         send(2'd2, 32'(k));
         chk("t5_rdy", 32'(istream_rdy), 32'd1);
         if (k > 0) begin
            chk("t5_val", 32'(ostream_val), 32'(3'b001));
            chk("t5_msg", s2, 32'(k - 1));
         end
         step();
      end
      istream_val = 1'b0;
      #1;
      chk("t5_last", s2, 32'd9);
      chk("t5_lval", 32'(ostream_val), 32'(3'b001));
      step();
      chk("t5_idle", 32'(ostream_val), 32'd0);

      // 5b: interleaved addrs 0/1/2
      for (int k = 0; k < 9; k++) begin
         send(2'(k % 3), 32'h100 + 32'(k));
         chk("t5i_rdy", 32'(istream_rdy), 32'd1);
         if (k > 0) begin
            chk("t5i_val", 32'(ostream_val), 32'(onehot((k - 1) % 3)));
            chk("t5i_msg", ostream_msg[(2 - (k - 1) % 3) * 32 +: 32],
                32'h100 + 32'(k - 1));
         end
         step();
      end
      istream_val = 1'b0;
      #1;
      chk("t5i_last", s2, 32'h108);
      step();
      chk("t5i_idle", 32'(ostream_val), 32'd0);

      // 6: reset mid-operation discards queued data
      ostream_rdy = 3'b000;
      send(2'd1, 32'hA1);
      step();
      send(2'd1, 32'hA2);
      step();
      istream_val = 1'b0;
      istream_msg = {2'd1, 32'h0};
      #1;
      chk("t6_q", 32'(ostream_val), 32'(3'b010));
      chk("t6_full", 32'(istream_rdy), 32'd0);
      reset = 1'b1;
      #1;
      chk("t6_rrdy", 32'(istream_rdy), 32'd0);
      chk("t6_rval", 32'(ostream_val), 32'd0);
      step();
      reset = 1'b0;
      #1;
      chk("t6_val", 32'(ostream_val), 32'd0);
      chk("t6_rdy", 32'(istream_rdy), 32'd1);
      ostream_rdy = 3'b111;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("t6_stale", 32'(ostream_val), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
